// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - ordered expected-store checker for the data-memory write port
// Compares each observed store to the head of a FIFO of expected stores and latches a verdict.
module mem_write_checker #(
   parameter int WIDTH             = 32,
   parameter int DEPTH             = 16,
   parameter int TIMEOUT           = 100,
   parameter int IGNORE_UNEXPECTED = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     exp_valid,
   output logic                     exp_ready,
   input  logic [WIDTH-1:0]         exp_addr,
   input  logic [WIDTH-1:0]         exp_data,
   input  logic                     start,
   input  logic                     MemWriteM,
   input  logic [WIDTH-1:0]         DataAdrM,
   input  logic [WIDTH-1:0]         WriteDataM,
   output logic [1:0]               state,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic [$clog2(DEPTH):0]   match_count,
   output logic [7:0]               unexpected_count,
   output logic [WIDTH-1:0]         err_addr,
   output logic [WIDTH-1:0]         err_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PASS = 2'd2, FAIL = 2'd3} stateT;

   stateT            stateR, stateN;
   logic [WIDTH-1:0] addrMem [DEPTH];
   logic [WIDTH-1:0] dataMem [DEPTH];
   logic [AW-1:0]    rdPtr, wrPtr;
   logic [AW:0]      count, countN;
   logic [CW-1:0]    cycleCnt, cycleCntN;
   logic             pushEn, popEn, headHit, missHit;
   logic             setTimeout, latchErr, bumpUnexp;

   assign state = stateR;

   // Stores only count against the head while RUN; an empty FIFO never matches.
   always_comb begin
      pushEn  = exp_valid && exp_ready;
      headHit = MemWriteM && (count != '0) &&
                (DataAdrM == addrMem[rdPtr]) && (WriteDataM == dataMem[rdPtr]);
      popEn   = (stateR == RUN) && headHit;
      missHit = (stateR == RUN) && MemWriteM && !headHit;
      countN  = count + (AW+1)'(pushEn) - (AW+1)'(popEn);
   end

   always_comb begin
      stateN     = stateR;
      cycleCntN  = cycleCnt;
      setTimeout = 1'b0;
      latchErr   = 1'b0;
      bumpUnexp  = 1'b0;
      case (stateR)
         IDLE: begin
            if (start) begin
               stateN    = RUN;
               cycleCntN = '0;
            end
         end
         RUN: begin
            if (missHit && IGNORE_UNEXPECTED == 0) begin
               stateN   = FAIL;
               latchErr = 1'b1;
            end else begin
               bumpUnexp = missHit;
               if (countN == '0) begin
                  stateN = PASS;
               end else if (cycleCnt == CW'(TIMEOUT - 1)) begin
                  stateN     = FAIL;
                  setTimeout = 1'b1;
               end else begin
                  cycleCntN = cycleCnt + CW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pushEn && !reset) begin
         addrMem[wrPtr] <= exp_addr;
         dataMem[wrPtr] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateR           <= IDLE;
         cycleCnt         <= '0;
         count            <= '0;
         rdPtr            <= '0;
         wrPtr            <= '0;
         exp_ready        <= 1'b1;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail             <= 1'b0;
         timeout          <= 1'b0;
         match_count      <= '0;
         unexpected_count <= '0;
         err_addr         <= '0;
         err_data         <= '0;
      end else begin
         stateR    <= stateN;
         cycleCnt  <= cycleCntN;
         count     <= countN;
         // Ready tracks the post-edge occupancy so a push into the last slot closes it next cycle.
         exp_ready <= (countN != (AW+1)'(DEPTH)) && (stateN == IDLE || stateN == RUN);
         done      <= (stateN == PASS) || (stateN == FAIL);
         pass      <= (stateN == PASS);
         fail      <= (stateN == FAIL);
         if (pushEn) wrPtr <= wrPtr + AW'(1);
         if (popEn) begin
            rdPtr       <= rdPtr + AW'(1);
            match_count <= match_count + (AW+1)'(1);
         end
         if (setTimeout) timeout <= 1'b1;
         if (latchErr) begin
            err_addr <= DataAdrM;
            err_data <= WriteDataM;
         end
         if (bumpUnexp && unexpected_count != 8'hFF)
            unexpected_count <= unexpected_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - randomized and directed bench for mem_write_checker
// Drives a strict and a skip-mode instance from the same stimulus and compares both to queue models.
module tb_mem_write_checker;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset, expValid, start, memWrite;
   logic [W-1:0] expAddr, expData, adr, wdata;

   logic         expReadyO [2];
   logic [1:0]   stO       [2];
   logic         doneO     [2];
   logic         passO     [2];
   logic         failO     [2];
   logic         timeoutO  [2];
   logic [2:0]   matchO    [2];
   logic [7:0]   unexpO    [2];
   logic [W-1:0] errAO     [2];
   logic [W-1:0] errDO     [2];

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .IGNORE_UNEXPECTED(0)) dutStrict (
      .clk(clk), .reset(reset), .exp_valid(expValid), .exp_ready(expReadyO[0]),
      .exp_addr(expAddr), .exp_data(expData), .start(start), .MemWriteM(memWrite),
      .DataAdrM(adr), .WriteDataM(wdata), .state(stO[0]), .done(doneO[0]), .pass(passO[0]),
      .fail(failO[0]), .timeout(timeoutO[0]), .match_count(matchO[0]),
      .unexpected_count(unexpO[0]), .err_addr(errAO[0]), .err_data(errDO[0]));

   mem_write_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .IGNORE_UNEXPECTED(1)) dutSkip (
      .clk(clk), .reset(reset), .exp_valid(expValid), .exp_ready(expReadyO[1]),
      .exp_addr(expAddr), .exp_data(expData), .start(start), .MemWriteM(memWrite),
      .DataAdrM(adr), .WriteDataM(wdata), .state(stO[1]), .done(doneO[1]), .pass(passO[1]),
      .fail(failO[1]), .timeout(timeoutO[1]), .match_count(matchO[1]),
      .unexpected_count(unexpO[1]), .err_addr(errAO[1]), .err_data(errDO[1]));

   // Reference model: verdict 0 idle, 1 run, 2 pass, 3 fail; expected stores kept as {addr,data}.
   logic [2*W-1:0] mq [2][$];
   int             mState [2];
   int             mMatch [2];
   int             mUnexp [2];
   int             mCyc   [2];
   logic           mTo    [2];
   logic [W-1:0]   mErrA  [2];
   logic [W-1:0]   mErrD  [2];

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelStep(input int k);
      logic rdy, push, hit, miss;
      int   newSize;
      if (reset) begin
         mq[k].delete();
         mState[k] = 0; mMatch[k] = 0; mUnexp[k] = 0; mCyc[k] = 0;
         mTo[k] = 1'b0; mErrA[k] = '0; mErrD[k] = '0;
         return;
      end
      rdy  = (mState[k] < 2) && (mq[k].size() < D);
      push = expValid && rdy;
      if (mState[k] == 0) begin
         if (push) mq[k].push_back({expAddr, expData});
         if (start) begin
            mState[k] = 1;
            mCyc[k]   = 0;
         end
      end else if (mState[k] == 1) begin
         hit  = memWrite && mq[k].size() > 0 && mq[k][0] == {adr, wdata};
         miss = memWrite && !hit;
         newSize = mq[k].size() + (push ? 1 : 0) - (hit ? 1 : 0);
         if (hit) begin
            void'(mq[k].pop_front());
            mMatch[k]++;
         end
         if (push) mq[k].push_back({expAddr, expData});
         if (miss && k == 0) begin
            mState[k] = 3;
            mErrA[k]  = adr;
            mErrD[k]  = wdata;
         end else begin
            if (miss && mUnexp[k] < 255) mUnexp[k]++;
            if (newSize == 0) mState[k] = 2;
            else if (mCyc[k] == TO - 1) begin
               mState[k] = 3;
               mTo[k]    = 1'b1;
            end else mCyc[k]++;
         end
      end
   endtask

   task automatic compareAll(input int k);
      string p;
      p = (k == 0) ? "strict" : "skip";
      checkEq({p, ".state"},   32'(stO[k]),       32'(mState[k]));
      checkEq({p, ".ready"},   32'(expReadyO[k]), 32'((mState[k] < 2) && (mq[k].size() < D)));
      checkEq({p, ".done"},    32'(doneO[k]),     32'(mState[k] >= 2));
      checkEq({p, ".pass"},    32'(passO[k]),     32'(mState[k] == 2));
      checkEq({p, ".fail"},    32'(failO[k]),     32'(mState[k] == 3));
      checkEq({p, ".timeout"}, 32'(timeoutO[k]),  32'(mTo[k]));
      checkEq({p, ".match"},   32'(matchO[k]),    32'(mMatch[k] % 8));
      checkEq({p, ".unexp"},   32'(unexpO[k]),    32'(mUnexp[k]));
      checkEq({p, ".errAddr"}, errAO[k],          mErrA[k]);
      checkEq({p, ".errData"}, errDO[k],          mErrD[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      #1;
      compareAll(0);
      compareAll(1);
   endtask

   task automatic clearIn();
      reset = 1'b0; expValid = 1'b0; start = 1'b0; memWrite = 1'b0;
      expAddr = '0; expData = '0; adr = '0; wdata = '0;
   endtask

   task automatic doReset();
      clearIn();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pushE(input logic [W-1:0] a, input logic [W-1:0] d);
      expValid = 1'b1; expAddr = a; expData = d;
      tick();
      expValid = 1'b0;
   endtask

   task automatic storeE(input logic [W-1:0] a, input logic [W-1:0] d);
      memWrite = 1'b1; adr = a; wdata = d;
      tick();
      memWrite = 1'b0;
   endtask

   task automatic startE();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int acc;
      clearIn();
      reset = 1'b1;
      tick();
      checkEq("reset_state", 32'(stO[0]), 32'd0);
      checkEq("reset_ready", 32'(expReadyO[0]), 32'd1);

      // Basic pass
      doReset();
      pushE(32'h64, 32'd7); pushE(32'h60, 32'd7); startE();
      storeE(32'h64, 32'd7);
      checkEq("basic_m1", 32'(matchO[0]), 32'd1);
      storeE(32'h60, 32'd7);
      checkEq("basic_m2", 32'(matchO[0]), 32'd2);
      checkEq("basic_pass", 32'(passO[0]), 32'd1);
      checkEq("basic_to", 32'(timeoutO[0]), 32'd0);

      // Mismatch on strict, counted skip on the other
      doReset();
      pushE(32'h64, 32'd7); startE(); storeE(32'h64, 32'd8);
      checkEq("mis_fail", 32'(failO[0]), 32'd1);
      checkEq("mis_addr", errAO[0], 32'h64);
      checkEq("mis_data", errDO[0], 32'd8);
      checkEq("mis_match", 32'(matchO[0]), 32'd0);

      // Skip mode
      doReset();
      pushE(32'h10, 32'd1); startE(); storeE(32'h20, 32'd5);
      storeE(32'h10, 32'd1);
      checkEq("skip_unexp", 32'(unexpO[1]), 32'd1);
      checkEq("skip_pass", 32'(passO[1]), 32'd1);

      // Timeout exactly TO edges after RUN is entered
      doReset();
      pushE(32'h5, 32'h5); startE();
      repeat (TO - 1) tick();
      checkEq("to_run", 32'(stO[0]), 32'd1);
      tick();
      checkEq("to_fail", 32'(stO[0]), 32'd3);
      checkEq("to_flag", 32'(timeoutO[0]), 32'd1);
      doReset();
      pushE(32'h5, 32'h5); startE();
      repeat (TO - 1) tick();
      storeE(32'h5, 32'h5);
      checkEq("to_lastpass", 32'(stO[0]), 32'd2);

      // Full / backpressure
      doReset();
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         expValid = 1'b1; expAddr = 32'(i); expData = 32'(i);
         if (expReadyO[0]) acc++;
         tick();
      end
      expValid = 1'b0;
      checkEq("full_acc", 32'(acc), 32'd4);
      checkEq("full_ready", 32'(expReadyO[0]), 32'd0);
      doReset();
      pushE(32'hA, 32'h1); startE();
      expValid = 1'b1; expAddr = 32'hB; expData = 32'h2;
      storeE(32'hA, 32'h1);
      expValid = 1'b0;
      checkEq("pp_state", 32'(stO[0]), 32'd1);
      storeE(32'hB, 32'h2);
      checkEq("pp_pass", 32'(stO[0]), 32'd2);

      // Reset mid-RUN with a store presented during reset
      doReset();
      pushE(32'h1, 32'h1); pushE(32'h2, 32'h2); startE(); storeE(32'h1, 32'h1);
      reset = 1'b1; memWrite = 1'b1; adr = 32'h2; wdata = 32'h2;
      tick();
      clearIn();
      checkEq("rst_state", 32'(stO[0]), 32'd0);
      checkEq("rst_match", 32'(matchO[0]), 32'd0);
      checkEq("rst_ready", 32'(expReadyO[0]), 32'd1);

      // Randomized episodes
      for (int ep = 0; ep < 200; ep++) begin
         int n;
         doReset();
         n = $urandom_range(0, 5);
         for (int i = 0; i < n; i++) begin
            expValid = ($urandom_range(0, 3) != 0);
            expAddr  = 32'($urandom_range(0, 3));
            expData  = 32'($urandom_range(0, 3));
            tick();
         end
         expValid = 1'b0;
         start = 1'b1;
         tick();
         for (int c = 0; c < 12; c++) begin
            start    = ($urandom_range(0, 7) == 0);
            expValid = ($urandom_range(0, 3) == 0);
            expAddr  = 32'($urandom_range(0, 3));
            expData  = 32'($urandom_range(0, 3));
            memWrite = ($urandom_range(0, 9) < 7);
            if (mq[1].size() > 0 && $urandom_range(0, 2) != 0) begin
               {adr, wdata} = mq[1][0];
            end else begin
               adr   = 32'($urandom_range(0, 3));
               wdata = 32'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 39) == 0);
            tick();
         end
         clearIn();
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
